noise_voice: RTL and testbench

NOISE_VOICE -- requirements
Module: noise_voice

---
 rtl/synth_pkg.sv | 15 +
 rtl/noise_env.sv | 85 ++++++++
 rtl/noise_voice.sv | 115 +++++++++++
 tb/tb_noise_voice.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/synth_pkg.sv
// Shared types and constants for the synth voice blocks.
package synth_pkg;

  // Full-scale envelope level.
  localparam int unsigned LEVEL_MAX = 255;

  // Envelope generator states.
  typedef enum logic [1:0] {
    EnvIdle,
    EnvAttack,
    EnvHold,
    EnvRelease
  } env_state_t;

endpackage

// File: rtl/noise_env.sv
// Attack/hold/release envelope generator; advances only on sample ticks.
// Level saturates at LEVEL_MAX and 0. LEVEL_W is expected to be at least 8.
module noise_env
  import synth_pkg::*;
#(
  parameter int unsigned LEVEL_W = 8
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               tick,
  input  logic               gate,
  input  logic [7:0]         attack_step,
  input  logic [7:0]         release_step,
  output logic [LEVEL_W-1:0] level
);

  localparam logic [LEVEL_W-1:0] LevelFull = LEVEL_W'(LEVEL_MAX);

  env_state_t         state_q, state_d;
  logic [LEVEL_W-1:0] level_q, level_d;
  logic [31:0]        att_sum;
  logic [LEVEL_W-1:0] att_sat;
  logic [LEVEL_W-1:0] rel_sat;

  // Saturating step arithmetic, widened so the add cannot wrap.
  always_comb begin
    att_sum = 32'(level_q) + 32'(attack_step);
    att_sat = (att_sum >= LEVEL_MAX) ? LevelFull : LEVEL_W'(att_sum);
    rel_sat = (32'(level_q) > 32'(release_step)) ? (level_q - LEVEL_W'(release_step))
                                                  : '0;
  end

  // Next state and level; a gate change wins over the step in the same tick.
  always_comb begin
    state_d = state_q;
    level_d = level_q;
    if (tick) begin
      case (state_q)
        EnvIdle: begin
          level_d = '0;
          if (gate) state_d = EnvAttack;
        end
        EnvAttack: begin
          if (!gate) begin
            state_d = EnvRelease;
          end else if (attack_step != 8'd0) begin
            level_d = att_sat;
            if (att_sat == LevelFull) state_d = EnvHold;
          end
        end
        EnvHold: begin
          level_d = LevelFull;
          if (!gate) state_d = EnvRelease;
        end
        EnvRelease: begin
          // Retrigger resumes attack from the current level.
          if (gate) begin
            state_d = EnvAttack;
          end else if (release_step != 8'd0) begin
            level_d = rel_sat;
            if (rel_sat == '0) state_d = EnvIdle;
          end
        end
        default: begin
          state_d = EnvIdle;
          level_d = '0;
        end
      endcase
    end
  end

  // Envelope state register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= EnvIdle;
      level_q <= '0;
    end else begin
      state_q <= state_d;
      level_q <= level_d;
    end
  end

  assign level = level_q;

endmodule

// File: rtl/noise_voice.sv
// Noise voice: divides the clock to a sample tick, strobes the LFSR, scales
// the noise word by the envelope level and offers it on a valid/ready port.
// Tick cycle T -> product formed in T+1 -> sample_valid in T+2.
module noise_voice
  import synth_pkg::*;
#(
  parameter int unsigned CLK_DIV = 2268,
  parameter int unsigned LEVEL_W = 8
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        gate,
  input  logic [7:0]  attack_step,
  input  logic [7:0]  release_step,
  output logic        lfsr_enable,
  input  logic [15:0] lfsr_data,
  output logic [15:0] sample,
  output logic        sample_valid,
  input  logic        sample_ready,
  output logic [7:0]  overrun_cnt
);

  localparam int unsigned CntW = $clog2(CLK_DIV);
  localparam int unsigned PW   = LEVEL_W + 16;
  localparam logic [CntW-1:0] CntLast = CntW'(CLK_DIV - 1);

  logic [CntW-1:0]    tick_cnt_q, tick_cnt_d;
  logic               tick_q, tick_d;
  logic               pend_q, pend_d;
  logic [15:0]        sample_q, sample_d;
  logic               valid_q, valid_d;
  logic [7:0]         ovr_q, ovr_d;
  logic [LEVEL_W-1:0] level;
  logic [PW-1:0]      noise_ext;
  logic [PW-1:0]      level_ext;
  logic signed [PW-1:0] product;
  logic [15:0]        sample_new;
  logic               accept;

  noise_env #(
    .LEVEL_W(LEVEL_W)
  ) u_env (
    .clk         (clk),
    .reset_n     (reset_n),
    .tick        (tick_q),
    .gate        (gate),
    .attack_step (attack_step),
    .release_step(release_step),
    .level       (level)
  );

  // Tick divider; the registered tick lands CLK_DIV cycles after reset release.
  always_comb begin
    tick_cnt_d = (tick_cnt_q == CntLast) ? '0 : tick_cnt_q + CntW'(1);
    tick_d     = (tick_cnt_q == CntLast);
    pend_d     = tick_q;
  end

  // Signed noise times unsigned level, floored back to 16 bits.
  always_comb begin
    noise_ext  = {{LEVEL_W{lfsr_data[15]}}, lfsr_data};
    level_ext  = {16'd0, level};
    product    = $signed(noise_ext) * $signed(level_ext);
    sample_new = 16'(product >>> LEVEL_W);
  end

  // Output handshake: load when free or draining this cycle, else count a drop.
  always_comb begin
    sample_d = sample_q;
    valid_d  = valid_q;
    ovr_d    = ovr_q;
    accept   = valid_q & sample_ready;
    if (accept) valid_d = 1'b0;
    if (pend_q) begin
      if (!valid_q || accept) begin
        sample_d = sample_new;
        valid_d  = 1'b1;
      end else if (ovr_q != 8'hFF) begin
        ovr_d = ovr_q + 8'd1;
      end
    end
  end

  // Tick timing registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tick_cnt_q <= '0;
      tick_q     <= 1'b0;
      pend_q     <= 1'b0;
    end else begin
      tick_cnt_q <= tick_cnt_d;
      tick_q     <= tick_d;
      pend_q     <= pend_d;
    end
  end

  // Output sample registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sample_q <= '0;
      valid_q  <= 1'b0;
      ovr_q    <= '0;
    end else begin
      sample_q <= sample_d;
      valid_q  <= valid_d;
      ovr_q    <= ovr_d;
    end
  end

  assign lfsr_enable  = tick_q;
  assign sample       = sample_q;
  assign sample_valid = valid_q;
  assign overrun_cnt  = ovr_q;

endmodule

// File: tb/tb_noise_voice.sv
// Directed bench for noise_voice with a short tick period.
module tb_noise_voice;
  import synth_pkg::*;

  localparam int unsigned CLK_DIV = 4;

  logic        clk;
  logic        reset_n;
  logic        gate;
  logic [7:0]  attack_step;
  logic [7:0]  release_step;
  logic        lfsr_enable;
  logic [15:0] lfsr_data;
  logic [15:0] sample;
  logic        sample_valid;
  logic        sample_ready;
  logic [7:0]  overrun_cnt;

  int n_cmp;
  int n_fail;

  noise_voice #(
    .CLK_DIV(CLK_DIV),
    .LEVEL_W(8)
  ) u_dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .gate        (gate),
    .attack_step (attack_step),
    .release_step(release_step),
    .lfsr_enable (lfsr_enable),
    .lfsr_data   (lfsr_data),
    .sample      (sample),
    .sample_valid(sample_valid),
    .sample_ready(sample_ready),
    .overrun_cnt (overrun_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Returns at the negedge of the next cycle with lfsr_enable high.
  task automatic wait_tick(input string tag);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!lfsr_enable && n < 3 * CLK_DIV);
    if (!lfsr_enable) check({tag, "_tick_timeout"}, 32'(lfsr_enable), 32'd1);
  endtask

  // Wait for a tick, then check the sample presented two cycles later.
  task automatic tick_sample(input string tag, input logic [15:0] exp);
    wait_tick(tag);
    @(negedge clk);
    @(negedge clk);
    check({tag, "_valid"}, 32'(sample_valid), 32'd1);
    check({tag, "_sample"}, 32'(sample), 32'(exp));
  endtask

  task automatic check_state(input string tag, input env_state_t exp);
    check(tag, 32'(u_dut.u_env.state_q), 32'(exp));
  endtask

  initial begin
    int n;
    logic saw_valid;
    n_cmp        = 0;
    n_fail       = 0;
    reset_n      = 1'b0;
    gate         = 1'b0;
    attack_step  = 8'd0;
    release_step = 8'd0;
    lfsr_data    = 16'h0000;
    sample_ready = 1'b1;

    // Reset values.
    repeat (3) @(negedge clk);
    check("rst_sample", 32'(sample), 32'd0);
    check("rst_valid", 32'(sample_valid), 32'd0);
    check("rst_lfsr_en", 32'(lfsr_enable), 32'd0);
    check("rst_overrun", 32'(overrun_cnt), 32'd0);
    check_state("rst_state", EnvIdle);

    // First tick arrives CLK_DIV cycles after release.
    reset_n = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!lfsr_enable && n < 20);
    check("first_tick_latency", 32'(n), 32'(CLK_DIV));
    @(negedge clk);
    check("valid_t1", 32'(sample_valid), 32'd0);
    @(negedge clk);
    check("valid_t2", 32'(sample_valid), 32'd1);
    check("idle_sample", 32'(sample), 32'd0);
    @(negedge clk);
    check("drained", 32'(sample_valid), 32'd0);

    // Tick spacing and idle samples with gate low.
    tick_sample("idle2", 16'h0000);
    wait_tick("period_a");
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!lfsr_enable && n < 20);
    check("tick_period", 32'(n), 32'(CLK_DIV));
    check("idle_overrun", 32'(overrun_cnt), 32'd0);
    @(negedge clk);

    // Attack to hold: -32768 * {0,100,200,255} / 256.
    gate         = 1'b1;
    attack_step  = 8'd100;
    release_step = 8'd100;
    lfsr_data    = 16'h8000;
    tick_sample("att_trig", 16'h0000);
    check_state("att_state", EnvAttack);
    tick_sample("att_100", 16'hCE00);
    tick_sample("att_200", 16'h9C00);
    tick_sample("att_255", 16'h8080);
    check_state("hold_state", EnvHold);
    tick_sample("hold", 16'h8080);

    // Release: 32767 * {255,155,55} / 256.
    gate      = 1'b0;
    lfsr_data = 16'h7FFF;
    tick_sample("rel_enter", 16'h7F7F);
    check_state("rel_state", EnvRelease);
    tick_sample("rel_155", 16'h4D7F);
    tick_sample("rel_55", 16'h1B7F);

    // Retrigger from 55 resumes attack without restarting from 0.
    gate = 1'b1;
    tick_sample("retrig", 16'h1B7F);
    check_state("retrig_state", EnvAttack);
    tick_sample("retrig_155", 16'h4D7F);
    check("retrig_level", 32'(u_dut.u_env.level_q), 32'd155);

    // Full release down to idle.
    gate = 1'b0;
    tick_sample("rel2_enter", 16'h4D7F);
    tick_sample("rel2_55", 16'h1B7F);
    tick_sample("rel2_0", 16'h0000);
    check_state("rel2_idle", EnvIdle);
    tick_sample("idle3", 16'h0000);
    check_state("idle3_state", EnvIdle);

    // Back to hold at full scale for the backpressure tests.
    gate        = 1'b1;
    attack_step = 8'd255;
    lfsr_data   = 16'h8000;
    tick_sample("bp_trig", 16'h0000);
    tick_sample("bp_full", 16'h8080);
    @(negedge clk);
    sample_ready = 1'b0;
    tick_sample("bp_load", 16'h8080);
    lfsr_data = 16'h7FFF;
    tick_sample("bp_drop1", 16'h8080);
    tick_sample("bp_drop2", 16'h8080);
    check("bp_overrun2", 32'(overrun_cnt), 32'd2);

    // One ready cycle drains the held sample.
    sample_ready = 1'b1;
    @(negedge clk);
    check("bp_drain", 32'(sample_valid), 32'd0);
    sample_ready = 1'b0;
    tick_sample("bp_next", 16'h7F7F);

    // Handshake in the load cycle replaces the sample without an overrun.
    lfsr_data = 16'h8000;
    wait_tick("hs_same");
    @(negedge clk);
    sample_ready = 1'b1;
    @(negedge clk);
    sample_ready = 1'b0;
    check("hs_valid", 32'(sample_valid), 32'd1);
    check("hs_sample", 32'(sample), 32'h8080);
    check("hs_overrun", 32'(overrun_cnt), 32'd2);

    // Long blockage saturates the drop counter.
    repeat (300) wait_tick("sat");
    @(negedge clk);
    @(negedge clk);
    check("sat_overrun", 32'(overrun_cnt), 32'd255);
    check("sat_sample", 32'(sample), 32'h8080);

    // Reset one cycle after a tick discards the pending sample.
    sample_ready = 1'b1;
    wait_tick("rst_mid");
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    check("mid_rst_sample", 32'(sample), 32'd0);
    check("mid_rst_valid", 32'(sample_valid), 32'd0);
    check("mid_rst_overrun", 32'(overrun_cnt), 32'd0);
    check("mid_rst_lfsr_en", 32'(lfsr_enable), 32'd0);
    @(negedge clk);
    reset_n   = 1'b1;
    saw_valid = 1'b0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
      if (sample_valid) saw_valid = 1'b1;
    end while (!lfsr_enable && n < 20);
    check("mid_rst_tick_latency", 32'(n), 32'(CLK_DIV));
    check("mid_rst_no_valid", 32'(saw_valid), 32'd0);
    @(negedge clk);
    @(negedge clk);
    check("post_rst_valid", 32'(sample_valid), 32'd1);
    check("post_rst_sample", 32'(sample), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
